// File: rtl/compare_nbit_pkg.sv
// Shared types and the compare function for the N-bit magnitude comparator.
//
// Contents:
//   cmp_res_t : 3-bit one-hot result, bit order {greater, equal, smaller}
//   CMP_GT/CMP_EQ/CMP_LT : the three legal one-hot codes
//   CMP_MAX_W : widest supported operand; cmp_f works at this width
//   cmp_f     : compare two operands, return a one-hot cmp_res_t
//
// Configuration macro: CMP_SIGNED_EN
//   defined   -> operands are two's-complement (callers sign-extend to CMP_MAX_W)
//   undefined -> operands are unsigned (callers zero-extend to CMP_MAX_W)
package compare_nbit_pkg;

   localparam int unsigned CMP_MAX_W   = 64;
   localparam int unsigned CMP_RES_W   = 3;

   typedef logic [CMP_RES_W-1:0] cmp_res_t;

   localparam cmp_res_t CMP_GT   = 3'b100;
   localparam cmp_res_t CMP_EQ   = 3'b010;
   localparam cmp_res_t CMP_LT   = 3'b001;
   localparam cmp_res_t CMP_NONE = 3'b000;

   // Width-generic compare: operands arrive already extended to CMP_MAX_W,
   // so a single function serves every CMP_WIDTH in 1..64.
   function automatic cmp_res_t cmp_f(input logic [CMP_MAX_W-1:0] a,
                                      input logic [CMP_MAX_W-1:0] b);
      cmp_res_t res;
      res = CMP_NONE;
      if (a == b) begin
         res = CMP_EQ;
      end
`ifdef CMP_SIGNED_EN
      else if ($signed(a) > $signed(b)) begin
         res = CMP_GT;
      end
`else
      else if (a > b) begin
         res = CMP_GT;
      end
`endif
      else begin
         res = CMP_LT;
      end
      return res;
   endfunction

endpackage : compare_nbit_pkg

// File: rtl/compare_nbit_core.sv
// Combinational compare core: one-hot relation plus max/min select.
//
// Parameters:
//   CMP_WIDTH : operand width, 1..64
// Ports:
//   a_i, b_i   : operands
//   res_o_c    : one-hot {greater, equal, smaller}
//   max_o_c    : larger operand (a_i when equal)
//   min_o_c    : smaller operand (b_i when equal)
//
// Configuration macro: CMP_SIGNED_EN selects two's-complement ordering.
module compare_nbit_core
   import compare_nbit_pkg::*;
#(
   parameter int unsigned CMP_WIDTH = 5
) (
   input  logic [CMP_WIDTH-1:0] a_i,
   input  logic [CMP_WIDTH-1:0] b_i,
   output cmp_res_t             res_o_c,
   output logic [CMP_WIDTH-1:0] max_o_c,
   output logic [CMP_WIDTH-1:0] min_o_c
);

   logic [CMP_MAX_W-1:0] a_ext;
   logic [CMP_MAX_W-1:0] b_ext;
   cmp_res_t             res_c;

   // Extend to the function width; signed builds must preserve the sign bit.
`ifdef CMP_SIGNED_EN
   assign a_ext = CMP_MAX_W'($signed(a_i));
   assign b_ext = CMP_MAX_W'($signed(b_i));
`else
   assign a_ext = CMP_MAX_W'(a_i);
   assign b_ext = CMP_MAX_W'(b_i);
`endif

   assign res_c = cmp_f(a_ext, b_ext);

   // Equal operands resolve to max=a, min=b.
   always_comb begin
      max_o_c = a_i;
      min_o_c = b_i;
      if (res_c == CMP_LT) begin
         max_o_c = b_i;
         min_o_c = a_i;
      end
   end

   assign res_o_c = res_c;

endmodule : compare_nbit_core

// File: rtl/compare_nbit_func_sync.sv
// Registered N-bit magnitude comparator with one-cycle latency.
//
// Parameters:
//   CMP_WIDTH : operand width, 1..64 (default 5)
// Ports:
//   clk       : rising-edge clock
//   reset     : asynchronous active-high reset
//   in_valid  : a/b sampled this cycle
//   a, b      : operands
//   out_valid : result registers were loaded on the previous edge
//   greater/equal/smaller : one-hot relation of a to b (all 0 until first sample)
//   max_out   : larger operand (a when equal)
//   min_out   : smaller operand (b when equal)
//
// Configuration macro: CMP_SIGNED_EN (defined -> two's-complement compare).
module compare_nbit_func_sync
   import compare_nbit_pkg::*;
#(
   parameter int unsigned CMP_WIDTH = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   input  logic [CMP_WIDTH-1:0] a,
   input  logic [CMP_WIDTH-1:0] b,
   output logic                 out_valid,
   output logic                 greater,
   output logic                 equal,
   output logic                 smaller,
   output logic [CMP_WIDTH-1:0] max_out,
   output logic [CMP_WIDTH-1:0] min_out
);

   cmp_res_t             res_c;
   logic [CMP_WIDTH-1:0] max_c;
   logic [CMP_WIDTH-1:0] min_c;

   cmp_res_t             res_q,   res_d;
   logic [CMP_WIDTH-1:0] max_q,   max_d;
   logic [CMP_WIDTH-1:0] min_q,   min_d;
   logic                 valid_q, valid_d;

   compare_nbit_core #(
      .CMP_WIDTH (CMP_WIDTH)
   ) u_core (
      .a_i     (a),
      .b_i     (b),
      .res_o_c (res_c),
      .max_o_c (max_c),
      .min_o_c (min_c)
   );

   // Load on valid input, otherwise hold the last result.
   always_comb begin
      res_d   = res_q;
      max_d   = max_q;
      min_d   = min_q;
      valid_d = in_valid;
      if (in_valid) begin
         res_d = res_c;
         max_d = max_c;
         min_d = min_c;
      end
   end

   // Result registers; reset drops any in-flight result immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         res_q   <= CMP_NONE;
         max_q   <= '0;
         min_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         res_q   <= res_d;
         max_q   <= max_d;
         min_q   <= min_d;
         valid_q <= valid_d;
      end
   end

   assign out_valid = valid_q;
   assign greater   = res_q[2];
   assign equal     = res_q[1];
   assign smaller   = res_q[0];
   assign max_out   = max_q;
   assign min_out   = min_q;

endmodule : compare_nbit_func_sync

// File: tb/tb_compare_nbit_func_sync.sv
// Directed, table-driven bench for compare_nbit_func_sync (CMP_WIDTH=5 and 1).
// Expected values follow CMP_SIGNED_EN when the macro is defined.
module tb_compare_nbit_func_sync;

   localparam int unsigned W = 5;

   logic         clk;
   logic         reset;
   logic         in_valid;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         greater;
   logic         equal;
   logic         smaller;
   logic [W-1:0] max_out;
   logic [W-1:0] min_out;

   logic         in_valid1;
   logic [0:0]   a1;
   logic [0:0]   b1;
   logic         out_valid1;
   logic         greater1;
   logic         equal1;
   logic         smaller1;
   logic [0:0]   max_out1;
   logic [0:0]   min_out1;

   int checks;
   int failures;

   compare_nbit_func_sync #(.CMP_WIDTH(W)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .greater   (greater),
      .equal     (equal),
      .smaller   (smaller),
      .max_out   (max_out),
      .min_out   (min_out)
   );

   compare_nbit_func_sync #(.CMP_WIDTH(1)) u_dut1 (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid1),
      .a         (a1),
      .b         (b1),
      .out_valid (out_valid1),
      .greater   (greater1),
      .equal     (equal1),
      .smaller   (smaller1),
      .max_out   (max_out1),
      .min_out   (min_out1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [2:0]   res;   // {greater, equal, smaller}
      logic [W-1:0] mx;
      logic [W-1:0] mn;
   } vec_t;

   localparam int NV = 10;
   vec_t vecs [NV];

   function automatic vec_t mk(input int va, input int vb, input logic [2:0] r,
                               input int vmx, input int vmn);
      vec_t v;
      v.a   = W'(va);
      v.b   = W'(vb);
      v.res = r;
      v.mx  = W'(vmx);
      v.mn  = W'(vmn);
      return v;
   endfunction

   // Packed observation: {out_valid, greater, equal, smaller, max, min}
   function automatic logic [31:0] obs();
      return 32'({out_valid, greater, equal, smaller, max_out, min_out});
   endfunction

   function automatic logic [31:0] obs1();
      return 32'({out_valid1, greater1, equal1, smaller1, max_out1, min_out1});
   endfunction

   function automatic logic [31:0] pk(input logic v, input logic [2:0] r,
                                      input logic [W-1:0] mx, input logic [W-1:0] mn);
      return 32'({v, r, mx, mn});
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got {v,g,e,s,max,min}=%h expected %h", name, act, exp);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;

      vecs[0] = mk(3,  2,  3'b100, 3,  2);
      vecs[1] = mk(3,  3,  3'b010, 3,  3);
      vecs[2] = mk(3,  3,  3'b010, 3,  3);   // repeated pair, same result
      vecs[3] = mk(9,  11, 3'b001, 11, 9);
      vecs[4] = mk(0,  0,  3'b010, 0,  0);
      vecs[5] = mk(31, 31, 3'b010, 31, 31);
      vecs[6] = mk(30, 31, 3'b001, 31, 30);
`ifdef CMP_SIGNED_EN
      vecs[7] = mk(31, 1,  3'b001, 1,  31);  // -1 < 1
      vecs[8] = mk(16, 15, 3'b001, 15, 16);  // -16 < 15
      vecs[9] = mk(0,  31, 3'b100, 0,  31);  // 0 > -1
`else
      vecs[7] = mk(31, 1,  3'b100, 31, 1);
      vecs[8] = mk(16, 15, 3'b100, 16, 15);
      vecs[9] = mk(0,  31, 3'b001, 31, 0);
`endif

      // Reset with operands left undriven
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_valid1 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", obs(), 32'd0);
      check("reset_state_w1", obs1(), 32'd0);

      @(negedge clk);
      reset = 1'b0;
      a  = '0;
      b  = '0;
      a1 = 1'b0;
      b1 = 1'b0;
      @(posedge clk);
      #1;
      check("idle_after_reset", obs(), 32'd0);

      // Back-to-back valid samples, one result per cycle
      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         a = vecs[i].a;
         b = vecs[i].b;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d", i), obs(),
               pk(1'b1, vecs[i].res, vecs[i].mx, vecs[i].mn));
      end

      // Drop valid and change operands: flags hold, out_valid clears
      @(negedge clk);
      in_valid = 1'b0;
      a = W'(7);
      b = W'(2);
      for (int k = 0; k < 2; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("hold%0d", k), obs(),
               pk(1'b0, vecs[NV-1].res, vecs[NV-1].mx, vecs[NV-1].mn));
      end

      // CMP_WIDTH=1: a=1, b=0
      @(negedge clk);
      in_valid1 = 1'b1;
      a1 = 1'b1;
      b1 = 1'b0;
      @(posedge clk);
      #1;
`ifdef CMP_SIGNED_EN
      check("w1_a1_b0", obs1(), 32'({1'b1, 3'b001, 1'b0, 1'b1}));
`else
      check("w1_a1_b0", obs1(), 32'({1'b1, 3'b100, 1'b1, 1'b0}));
`endif
      @(negedge clk);
      in_valid1 = 1'b0;

      // Sign check then asynchronous reset mid-stream
      @(negedge clk);
      in_valid = 1'b1;
      a = W'(31);
      b = W'(1);
      @(posedge clk);
      #1;
      check("sign_31_1", obs(), pk(1'b1, vecs[7].res, vecs[7].mx, vecs[7].mn));
      #2;
      reset = 1'b1;
      #1;
      check("async_reset_immediate", obs(), 32'd0);
      check("async_reset_immediate_w1", obs1(), 32'd0);
      @(negedge clk);
      in_valid = 1'b0;
      reset    = 1'b0;
      @(posedge clk);
      #1;
      check("after_reset_release", obs(), 32'd0);

      // Recovery after reset
      @(negedge clk);
      in_valid = 1'b1;
      a = W'(4);
      b = W'(12);
      @(posedge clk);
      #1;
      check("recover_4_12", obs(), pk(1'b1, 3'b001, W'(12), W'(4)));
      @(negedge clk);
      in_valid = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_compare_nbit_func_sync
